// File: rtl/video_cfg_sequencer_if.sv
// AXI4-Lite write channel bundle between the config sequencer (master) and
// the video IP register space (slave).
interface video_cfg_sequencer_if;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_awready, m_wready, m_bresp, m_bvalid
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_awready, m_wready, m_bresp, m_bvalid
    );
endinterface

// File: rtl/video_cfg_sequencer.sv
// Standalone AXI4-Lite write sequencer: programs TPG and demosaic frame
// parameters, releases the crop stage via ap_start, then starts both cores.
module video_cfg_sequencer #(
    parameter logic [31:0] TPG_BASE    = 32'h0000_0000,
    parameter logic [31:0] DMS_BASE    = 32'h0001_0000,
    parameter logic [31:0] BG_PATTERN  = 32'd9,
    parameter logic [31:0] BAYER_PHASE = 32'd0,
    parameter int unsigned START_DELAY = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cfg_go,
    input  logic [15:0]           hsize,
    input  logic [15:0]           vsize,
    video_cfg_sequencer_if.master axi,
    output logic                  ap_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_B,
        DELAY,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  dly_cnt;
    logic        aw_ok;
    logic        w_ok;
    logic [15:0] hs_q;
    logic [15:0] vs_q;

    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;

    function automatic logic [31:0] cmd_addr(input logic [2:0] i);
        case (i)
            3'd0:    cmd_addr = TPG_BASE + 32'h10;
            3'd1:    cmd_addr = TPG_BASE + 32'h18;
            3'd2:    cmd_addr = TPG_BASE + 32'h20;
            3'd3:    cmd_addr = DMS_BASE + 32'h10;
            3'd4:    cmd_addr = DMS_BASE + 32'h18;
            3'd5:    cmd_addr = DMS_BASE + 32'h28;
            3'd6:    cmd_addr = DMS_BASE;
            default: cmd_addr = TPG_BASE;
        endcase
    endfunction

    function automatic logic [31:0] cmd_data(input logic [2:0]  i,
                                             input logic [15:0] hs,
                                             input logic [15:0] vs);
        case (i)
            3'd0:    cmd_data = {16'h0000, vs};
            3'd1:    cmd_data = {16'h0000, hs};
            3'd2:    cmd_data = BG_PATTERN;
            3'd3:    cmd_data = {16'h0000, hs};
            3'd4:    cmd_data = {16'h0000, vs};
            3'd5:    cmd_data = BAYER_PHASE;
            default: cmd_data = 32'h0000_0081;
        endcase
    endfunction

    assign aw_hs  = awvalid_r & axi.m_awready;
    assign w_hs   = wvalid_r & axi.m_wready;
    assign aw_fin = aw_ok | aw_hs;
    assign w_fin  = w_ok | w_hs;

    assign axi.m_awaddr  = awaddr_r;
    assign axi.m_awvalid = awvalid_r;
    assign axi.m_wdata   = wdata_r;
    assign axi.m_wstrb   = 4'hF;
    assign axi.m_wvalid  = wvalid_r;
    assign axi.m_bready  = bready_r;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            dly_cnt   <= 8'd0;
            aw_ok     <= 1'b0;
            w_ok      <= 1'b0;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            ap_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (cfg_go) begin
                        hs_q      <= hsize;
                        vs_q      <= vsize;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        ap_start  <= 1'b0;
                        busy      <= 1'b1;
                        idx       <= 3'd0;
                        awaddr_r  <= cmd_addr(3'd0);
                        wdata_r   <= cmd_data(3'd0, hsize, vsize);
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        aw_ok     <= 1'b0;
                        w_ok      <= 1'b0;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Each channel retires independently; move on once both have.
                    if (aw_hs) begin
                        awvalid_r <= 1'b0;
                        aw_ok     <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_r <= 1'b0;
                        w_ok     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_ok    <= 1'b0;
                        w_ok     <= 1'b0;
                        bready_r <= 1'b1;
                        state    <= WAIT_B;
                    end
                end

                WAIT_B: begin
                    if (axi.m_bvalid) begin
                        bready_r <= 1'b0;
                        if (axi.m_bresp != 2'b00) begin
                            err      <= 1'b1;
                            ap_start <= 1'b0;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end else if (idx == 3'd5) begin
                            dly_cnt <= 8'(START_DELAY - 1);
                            state   <= DELAY;
                        end else if (idx == 3'd7) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx       <= idx + 3'd1;
                            awaddr_r  <= cmd_addr(idx + 3'd1);
                            wdata_r   <= cmd_data(idx + 3'd1, hs_q, vs_q);
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                DELAY: begin
                    // Crop stage is released together with the first start write.
                    if (dly_cnt == 8'd0) begin
                        ap_start  <= 1'b1;
                        idx       <= 3'd6;
                        awaddr_r  <= cmd_addr(3'd6);
                        wdata_r   <= cmd_data(3'd6, hs_q, vs_q);
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Directed bench for video_cfg_sequencer: a configurable AXI4-Lite slave
// records every write and is compared against hand-computed command tables.
module tb_video_cfg_sequencer;

    localparam int SD = 10;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_go;
    logic [15:0] hsize;
    logic [15:0] vsize;
    logic        ap_start;
    logic        busy;
    logic        done;
    logic        err;

    video_cfg_sequencer_if bus ();

    video_cfg_sequencer #(
        .START_DELAY(SD)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_go   (cfg_go),
        .hsize    (hsize),
        .vsize    (vsize),
        .axi      (bus),
        .ap_start (ap_start),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 aclk = ~aclk;

    int chk_total = 0;
    int chk_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_total++;
        if (got === exp) chk_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [31:0] exp_a [8] = '{32'h10, 32'h18, 32'h20, 32'h1_0010,
                               32'h1_0018, 32'h1_0028, 32'h1_0000, 32'h0};
    logic [31:0] exp_d [2][8] = '{
        '{32'd640,  32'd480,  32'd9, 32'd480,  32'd640,  32'd0, 32'h81, 32'h81},
        '{32'd1080, 32'd1920, 32'd9, 32'd1920, 32'd1080, 32'd0, 32'h81, 32'h81}
    };

    // Slave model knobs and observations
    int          aw_lat, w_lat, err_idx, stall_idx;
    logic        clr;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got, bpend;
    logic [31:0] aw_q, w_q;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cnt, aw_hs_cnt, stab_err;
    int          cyc = 0;
    int          b5_cyc, ap_rise;
    logic        ap_q, ap_at_aw6;
    logic        aw_pend_q, w_pend_q;
    logic [31:0] awaddr_q2, wdata_q2;

    logic aw_hs, w_hs, aw_f, w_f;
    assign bus.m_awready = !aw_got && (aw_cnt >= aw_lat);
    assign bus.m_wready  = !w_got && (w_cnt >= w_lat);
    assign aw_hs = bus.m_awvalid && bus.m_awready;
    assign w_hs  = bus.m_wvalid && bus.m_wready;
    assign aw_f  = aw_got || aw_hs;
    assign w_f   = w_got || w_hs;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (areset || clr) begin
            aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0;
            bus.m_bvalid <= 1'b0; bus.m_bresp <= 2'b00;
            wr_cnt <= 0; aw_hs_cnt <= 0; stab_err <= 0;
            aw_pend_q <= 1'b0; w_pend_q <= 1'b0;
            ap_q <= 1'b0; ap_at_aw6 <= 1'b0; b5_cyc <= -100; ap_rise <= -200;
        end else begin
            ap_q <= ap_start;
            if (ap_start && !ap_q) ap_rise <= cyc;
            if (aw_pend_q && (!bus.m_awvalid || bus.m_awaddr != awaddr_q2)) stab_err <= stab_err + 1;
            if (w_pend_q && (!bus.m_wvalid || bus.m_wdata != wdata_q2)) stab_err <= stab_err + 1;
            aw_pend_q <= bus.m_awvalid && !bus.m_awready;
            w_pend_q  <= bus.m_wvalid && !bus.m_wready;
            awaddr_q2 <= bus.m_awaddr;
            wdata_q2  <= bus.m_wdata;
            if (aw_hs) begin
                aw_hs_cnt <= aw_hs_cnt + 1;
                if (wr_cnt == 6) ap_at_aw6 <= ap_start;
            end
            if (bus.m_bvalid && bus.m_bready) begin
                bus.m_bvalid <= 1'b0;
                if (wr_cnt == 6) b5_cyc <= cyc;
            end
            if (aw_f && w_f) begin
                if (wr_cnt < 16) begin
                    wr_addr[wr_cnt] <= aw_got ? aw_q : bus.m_awaddr;
                    wr_data[wr_cnt] <= w_got ? w_q : bus.m_wdata;
                end
                bus.m_bresp <= (wr_cnt == err_idx) ? 2'b10 : 2'b00;
                if (wr_cnt == stall_idx) bpend <= 1'b1;
                else bus.m_bvalid <= 1'b1;
                wr_cnt <= wr_cnt + 1;
                aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_q <= bus.m_awaddr; end
                if (w_hs)  begin w_got <= 1'b1;  w_q <= bus.m_wdata;   end
                if (bus.m_awvalid && !aw_got && !bus.m_awready) aw_cnt <= aw_cnt + 1;
                if (bus.m_wvalid && !w_got && !bus.m_wready) w_cnt <= w_cnt + 1;
            end
        end
    end

    task automatic clear_slave();
        @(negedge aclk); clr = 1'b1;
        @(negedge aclk); clr = 1'b0;
    endtask

    task automatic start_seq(input logic [15:0] h, input logic [15:0] v);
        @(negedge aclk); hsize = h; vsize = v; cfg_go = 1'b1;
        @(negedge aclk); cfg_go = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || err) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_finished"}, {31'b0, done | err}, 32'd1);
    endtask

    task automatic check_writes(input string tag, input int n, input int set);
        check({tag, "_wrcnt"}, wr_cnt, n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_d[set][i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awaddr"},  bus.m_awaddr, 32'h0);
        check({tag, "_awvalid"}, {31'b0, bus.m_awvalid}, 32'd0);
        check({tag, "_wdata"},   bus.m_wdata, 32'h0);
        check({tag, "_wvalid"},  {31'b0, bus.m_wvalid}, 32'd0);
        check({tag, "_wstrb"},   {28'b0, bus.m_wstrb}, 32'hF);
        check({tag, "_bready"},  {31'b0, bus.m_bready}, 32'd0);
        check({tag, "_status"},  {28'b0, ap_start, busy, done, err}, 32'd0);
    endtask

    task automatic check_done_run(input string tag, input int set);
        check({tag, "_status"}, {28'b0, ap_start, busy, done, err}, 32'b1010);
        check_writes(tag, 8, set);
        check({tag, "_stable"}, stab_err, 32'd0);
        check({tag, "_ap_delay"}, ap_rise - b5_cyc, SD + 1);
        check({tag, "_ap_before_aw6"}, {31'b0, ap_at_aw6}, 32'd1);
    endtask

    initial begin
        areset = 1'b1; cfg_go = 1'b0; hsize = 16'd0; vsize = 16'd0; clr = 1'b0;
        aw_lat = 0; w_lat = 0; err_idx = -1; stall_idx = -1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check_idle_outputs("reset");

        // Always-ready slave
        clear_slave();
        start_seq(16'd480, 16'd640);
        check("start_busy", {31'b0, busy}, 32'd1);
        wait_end("ready");
        check_done_run("ready", 0);

        // W accepted three cycles before AW
        aw_lat = 3; w_lat = 0;
        clear_slave();
        start_seq(16'd480, 16'd640);
        wait_end("wfirst");
        check_done_run("wfirst", 0);

        // AW accepted before W
        aw_lat = 0; w_lat = 2;
        clear_slave();
        start_seq(16'd1920, 16'd1080);
        wait_end("awfirst");
        check_done_run("awfirst", 1);
        w_lat = 0;

        // SLVERR on idx3
        err_idx = 3;
        clear_slave();
        start_seq(16'd480, 16'd640);
        wait_end("slverr");
        repeat (20) @(negedge aclk);
        check("slverr_status", {28'b0, ap_start, busy, done, err}, 32'b0001);
        check("slverr_aw_count", aw_hs_cnt, 32'd4);
        check("slverr_awvalid", {31'b0, bus.m_awvalid}, 32'd0);
        check_writes("slverr", 4, 0);
        err_idx = -1;

        // Reset while waiting for the idx2 response
        stall_idx = 2;
        clear_slave();
        start_seq(16'd480, 16'd640);
        begin
            int n = 0;
            while (!(wr_cnt == 3 && bus.m_bready) && n < 200) begin
                @(negedge aclk);
                n++;
            end
            check("rst_reached_waitb_idx2", {31'b0, wr_cnt == 3 && bus.m_bready}, 32'd1);
        end
        areset = 1'b1; stall_idx = -1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check_idle_outputs("midreset");
        start_seq(16'd1920, 16'd1080);
        wait_end("restart");
        check_done_run("restart", 1);

        // cfg_go while busy is ignored; cfg_go after done restarts
        clear_slave();
        start_seq(16'd480, 16'd640);
        repeat (5) @(negedge aclk);
        check("go_busy_pre", {31'b0, busy}, 32'd1);
        cfg_go = 1'b1; hsize = 16'd1920; vsize = 16'd1080;
        @(negedge aclk); cfg_go = 1'b0;
        wait_end("gobusy");
        check_done_run("gobusy", 0);
        clear_slave();
        start_seq(16'd1920, 16'd1080);
        check("rerun_clear", {28'b0, ap_start, busy, done, err}, 32'b0100);
        wait_end("rerun");
        check_done_run("rerun", 1);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
